hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Backward-flowing control for the 5-stage MIPS pipeline.
- Observes stage-register contents (ID operands, EX load destination, M memory handshake) and drives the write, bubble and flush controls of the PC and the IF_ID/ID_EX/EX_M/M_WB registers.
- Handles three hazard classes:
  - load-use stalls of configurable length;
  - taken-branch/jump squash of the fetched instruction;
  - multi-cycle data-memory waits with timeout.

Parameters:
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_err (1..65535).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- ID_Rs  input  5  Rs field of the instruction in ID
- ID_Rt  input  5  Rt field of the instruction in ID
- ID_uses_Rt  input  1  ID instruction reads Rt (R-type, beq, bne, sw)
- EX_Rt  input  5  destination Rt of the instruction in EX
- EX_MemRead  input  1  EX instruction is a load
- branch_taken_ID  input  1  branch/jump resolved taken in ID this cycle
- mem_req  input  1  M-stage instruction accesses data memory
- mem_ready  input  1  data memory completes the access this cycle
- PC_write  output  1  PC load enable
- IF_ID_write  output  1  IF_ID load enable
- IF_ID_flush  output  1  IF_ID loads a NOP (all-zero instruction)
- ID_EX_bubble  output  1  ID_EX loads zero control fields
- ID_EX_write  output  1  ID_EX load enable
- EX_M_write  output  1  EX_M load enable
- M_WB_bubble  output  1  M_WB loads zero WB control
- mem_err  output  1  sticky memory-timeout flag
- stall_cnt  output  32  load-use bubble count
- flush_cnt  output  32  squash count
- memwait_cnt  output  32  memory wait-cycle count

Behaviour:
- State register: RUN, LU_STALL, MEM_WAIT. A down-counter `cnt` (16 bit) is also kept.
- Outputs are combinational functions of the registered state and the current inputs. They take effect on the same clock edge at which the pipeline registers sample.
- Default, RUN with no hazard: PC_write=1, IF_ID_write=1, ID_EX_write=1, EX_M_write=1, all bubble/flush outputs=0.
- Load-use condition (lu): EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_uses_Rt && EX_Rt==ID_Rt)).
- Memory wait condition (mw): mem_req && !mem_ready.
- Priority: mw > lu > branch_taken_ID.
- RUN:
  - mw: freeze. PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_M_write=0, M_WB_bubble=1. Go to MEM_WAIT with cnt=MEM_TIMEOUT-1.
  - else lu: PC_write=0, IF_ID_write=0, ID_EX_bubble=1. If LOAD_USE_CYCLES>1, go to LU_STALL with cnt=LOAD_USE_CYCLES-2.
  - else branch_taken_ID: IF_ID_flush=1; PC_write and IF_ID_write stay 1.
- LU_STALL:
  - Same outputs as the lu case, independent of lu.
  - Decrement cnt; return to RUN when cnt==0.
  - mw has priority: go to MEM_WAIT; the remaining stall count is discarded.
  - branch_taken_ID is ignored here, because the ID instruction is re-presented.
- MEM_WAIT:
  - Freeze outputs as in RUN/mw while !mem_ready.
  - When mem_ready=1: same cycle, all enables=1 and M_WB_bubble=0 (lu and branch evaluated as in RUN); go to RUN.
  - cnt decrements each waiting cycle. At cnt==0 with still !mem_ready, set mem_err=1.
  - After mem_err is set, remain in MEM_WAIT and keep freezing until mem_ready.
- mem_err clears only on reset.
- Reset (rst_n=0 at a clock edge):
  - state=RUN, cnt=0, mem_err=0, counters=0.
  - While rst_n=0, outputs are forced: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, ID_EX_write=1, EX_M_write=1, M_WB_bubble=1.
  - Reset asserted mid-stall or mid-wait aborts to RUN.
- Register $0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_cnt +1 per cycle ID_EX_bubble=1 from lu/LU_STALL.
  - flush_cnt +1 per IF_ID_flush from a branch.
  - memwait_cnt +1 per freeze cycle.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: the three ports remain present and are tied to 0; no counter flops are built.

Test Plan:
- lw $5 in EX (EX_MemRead=1, EX_Rt=5), ID_Rs=5, LOAD_USE_CYCLES=1 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle all defaults; stall_cnt=1 (macro on).
- EX_Rt=0 load, ID_Rs=0 -> no stall. Then EX_Rt=7, ID_Rt=7, ID_uses_Rt=0 -> no stall. Then ID_uses_Rt=1 -> stall.
- branch_taken_ID=1 in RUN, no hazards -> IF_ID_flush=1 for exactly that cycle, PC_write=1; flush_cnt=1. Same branch coincident with lu -> stall only, no flush.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 freeze cycles (EX_M_write=0, M_WB_bubble=1), release on the 4th; memwait_cnt=3; mem_err=0.
- MEM_TIMEOUT=4, mem_ready held low 6 cycles -> mem_err=1 after 4th wait cycle; freeze continues; mem_err stays 1 after mem_ready; cleared only by rst_n=0.
- LOAD_USE_CYCLES=3 with rst_n driven low in the 2nd stall cycle -> next cycle state RUN, reset output values while low, defaults after release.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch-squash / memory-wait pipeline control; counters built only with HAZARD_STATS_EN
module hazard_stall_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_uses_Rt,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_MemRead,
  input  logic        branch_taken_ID,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        ID_EX_write,
  output logic        EX_M_write,
  output logic        M_WB_bubble,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cnt
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  localparam logic [15:0] TO_INIT = 16'(MEM_TIMEOUT - 1);
  localparam logic [15:0] LU_INIT = 16'(LOAD_USE_CYCLES - 2);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        lu, mw, frz, stl, flu;
  assign lu = EX_MemRead && EX_Rt != 5'd0 && (EX_Rt == ID_Rs || (ID_uses_Rt && EX_Rt == ID_Rt));
  assign mw = mem_req && !mem_ready;
  // next state, stall counter and the freeze/stall/flush decisions; a released MEM_WAIT behaves like RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frz     = 1'b0;
    stl     = 1'b0;
    flu     = 1'b0;
    if (state_q == LU_STALL && !mw) begin
      stl     = 1'b1;
      state_d = cnt_q == 16'd0 ? RUN : LU_STALL;
      cnt_d   = cnt_q == 16'd0 ? 16'd0 : cnt_q - 16'd1;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      frz   = 1'b1;
      cnt_d = cnt_q == 16'd0 ? 16'd0 : cnt_q - 16'd1;
    end else if (mw) begin
      frz     = 1'b1;
      state_d = MEM_WAIT;
      cnt_d   = TO_INIT;
    end else if (lu && state_q != LU_STALL) begin
      stl     = 1'b1;
      state_d = LOAD_USE_CYCLES > 1 ? LU_STALL : RUN;
      cnt_d   = LOAD_USE_CYCLES > 1 ? LU_INIT : cnt_q;
    end else begin
      state_d = RUN;
      flu     = branch_taken_ID;
    end
    mem_err_d = mem_err_q || (frz && cnt_d == 16'd0);
  end
  // control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= 16'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign PC_write     = rst_n && !(frz || stl);
  assign IF_ID_write  = rst_n && !(frz || stl);
  assign IF_ID_flush  = !rst_n || flu;
  assign ID_EX_bubble = !rst_n || stl;
  assign ID_EX_write  = !rst_n || !frz;
  assign EX_M_write   = !rst_n || !frz;
  assign M_WB_bubble  = !rst_n || frz;
  assign mem_err      = mem_err_q;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, memwait_cnt_q, memwait_cnt_d;
  // event counters, wrapping naturally at 2^32
  always_comb begin
    stall_cnt_d   = stall_cnt_q + 32'(stl);
    flush_cnt_d   = flush_cnt_q + 32'(flu);
    memwait_cnt_d = memwait_cnt_q + 32'(frz);
  end
  // counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
      memwait_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  assign stall_cnt   = 32'd0;
  assign flush_cnt   = 32'd0;
  assign memwait_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of hazard_stall_ctrl with LOAD_USE_CYCLES=1/MEM_TIMEOUT=4 and LOAD_USE_CYCLES=3
module tb_hazard_stall_ctrl;
`ifdef HAZARD_STATS_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif
  // output vector order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write, EX_M_write, M_WB_bubble
  localparam logic [6:0] DEF = 7'b1100110;
  localparam logic [6:0] STL = 7'b0001110;
  localparam logic [6:0] FLU = 7'b1110110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] RST = 7'b0011111;
  logic clk = 1'b0, rst_n;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic ID_uses_Rt, EX_MemRead, branch_taken_ID, mem_req, mem_ready;
  logic pw1, iw1, if1, ib1, iew1, ew1, mb1, err1, pw3, iw3, if3, ib3, iew3, ew3, mb3, err3;
  logic [31:0] sc1, fc1, mc1, sc3, fc3, mc3;
  logic [6:0] o1, o3;
  int n_chk = 0, n_fail = 0;
  assign o1 = {pw1, iw1, if1, ib1, iew1, ew1, mb1};
  assign o3 = {pw3, iw3, if3, ib3, iew3, ew3, mb3};
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT(4)) d1 (
    .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt), .EX_Rt(EX_Rt),
    .EX_MemRead(EX_MemRead), .branch_taken_ID(branch_taken_ID), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(pw1), .IF_ID_write(iw1), .IF_ID_flush(if1), .ID_EX_bubble(ib1), .ID_EX_write(iew1),
    .EX_M_write(ew1), .M_WB_bubble(mb1), .mem_err(err1), .stall_cnt(sc1), .flush_cnt(fc1), .memwait_cnt(mc1));
  hazard_stall_ctrl #(.LOAD_USE_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt), .EX_Rt(EX_Rt),
    .EX_MemRead(EX_MemRead), .branch_taken_ID(branch_taken_ID), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(pw3), .IF_ID_write(iw3), .IF_ID_flush(if3), .ID_EX_bubble(ib3), .ID_EX_write(iew3),
    .EX_M_write(ew3), .M_WB_bubble(mb3), .mem_err(err3), .stall_cnt(sc3), .flush_cnt(fc3), .memwait_cnt(mc3));
  task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; ID_Rs = '0; ID_Rt = '0; EX_Rt = '0; ID_uses_Rt = 1'b0; EX_MemRead = 1'b0;
    branch_taken_ID = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #1 ck("rst_forced_out", 32'(o1), 32'(RST));
    tick(); tick();
    rst_n = 1'b1;
    #1 ck("run_default", 32'(o1), 32'(DEF));
    ck("rst_mem_err", 32'(err1), 32'd0);
    ck("rst_stall_cnt", sc1, 32'd0);
    ck("rst_memwait_cnt", mc1, 32'd0);
    EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rs = 5'd5;
    #1 ck("lu_rs_stall", 32'(o1), 32'(STL));
    tick();
    EX_MemRead = 1'b0;
    #1 ck("lu_rs_release", 32'(o1), 32'(DEF));
    ck("lu_rs_stall_cnt", sc1, S ? 32'd1 : 32'd0);
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    #1 ck("lu_r0_nostall", 32'(o1), 32'(DEF));
    EX_Rt = 5'd7; ID_Rs = 5'd1; ID_Rt = 5'd7; ID_uses_Rt = 1'b0;
    #1 ck("lu_rt_unused", 32'(o1), 32'(DEF));
    ID_uses_Rt = 1'b1;
    #1 ck("lu_rt_stall", 32'(o1), 32'(STL));
    tick();
    EX_MemRead = 1'b0;
    #1 ck("lu_rt_release", 32'(o1), 32'(DEF));
    branch_taken_ID = 1'b1;
    #1 ck("branch_flush", 32'(o1), 32'(FLU));
    tick();
    branch_taken_ID = 1'b0;
    #1 ck("branch_one_cycle", 32'(o1), 32'(DEF));
    ck("flush_cnt_1", fc1, S ? 32'd1 : 32'd0);
    branch_taken_ID = 1'b1; EX_MemRead = 1'b1;
    #1 ck("lu_beats_branch", 32'(o1), 32'(STL));
    tick();
    branch_taken_ID = 1'b0; EX_MemRead = 1'b0;
    #1 ck("lu_branch_release", 32'(o1), 32'(DEF));
    ck("stall_cnt_3", sc1, S ? 32'd3 : 32'd0);
    ck("flush_cnt_still_1", fc1, S ? 32'd1 : 32'd0);
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 ck("mw_freeze_1", 32'(o1), 32'(FRZ));
    tick();
    ck("mw_freeze_2", 32'(o1), 32'(FRZ));
    tick();
    ck("mw_freeze_3", 32'(o1), 32'(FRZ));
    tick();
    mem_ready = 1'b1;
    #1 ck("mw_release", 32'(o1), 32'(DEF));
    ck("mw_no_err", 32'(err1), 32'd0);
    tick();
    mem_req = 1'b0;
    #1 ck("mw_after_release", 32'(o1), 32'(DEF));
    ck("memwait_cnt_3", mc1, S ? 32'd3 : 32'd0);
    ck("mw3_no_err", 32'(err1), 32'd0);
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1 ck($sformatf("to_freeze_%0d", i), 32'(o1), 32'(FRZ));
      ck($sformatf("to_err_%0d", i), 32'(err1), i >= 5 ? 32'd1 : 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1 ck("to_release", 32'(o1), 32'(DEF));
    tick();
    mem_req = 1'b0;
    #1 ck("to_err_sticky", 32'(err1), 32'd1);
    ck("memwait_cnt_9", mc1, S ? 32'd9 : 32'd0);
    rst_n = 1'b0;
    #1 ck("rst_out_again", 32'(o1), 32'(RST));
    tick();
    rst_n = 1'b1;
    #1 ck("rst_clears_err", 32'(err1), 32'd0);
    ck("rst_clears_memwait", mc1, 32'd0);
    ck("rst_clears_flush", fc1, 32'd0);
    EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rs = 5'd5;
    #1 ck("lu3_c1", 32'(o3), 32'(STL));
    tick();
    EX_MemRead = 1'b0;
    branch_taken_ID = 1'b1;
    #1 ck("lu3_c2_ignores_branch", 32'(o3), 32'(STL));
    tick();
    #1 ck("lu3_c3", 32'(o3), 32'(STL));
    tick();
    branch_taken_ID = 1'b0;
    #1 ck("lu3_done", 32'(o3), 32'(DEF));
    ck("lu3_stall_cnt", sc3, S ? 32'd3 : 32'd0);
    ck("lu3_flush_cnt", fc3, 32'd0);
    EX_MemRead = 1'b1;
    #1 ck("lu3r_c1", 32'(o3), 32'(STL));
    tick();
    EX_MemRead = 1'b0;
    #1 ck("lu3r_c2", 32'(o3), 32'(STL));
    rst_n = 1'b0;
    #1 ck("lu3r_rst_out", 32'(o3), 32'(RST));
    tick();
    ck("lu3r_rst_held", 32'(o3), 32'(RST));
    ck("lu3r_rst_cnt", sc3, 32'd0);
    rst_n = 1'b1;
    #1 ck("lu3r_aborted_to_run", 32'(o3), 32'(DEF));
    tick();
    ck("lu3r_run_next", 32'(o3), 32'(DEF));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
